fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 37 +++
 rtl/fetch_sequencer.sv | 80 ++++++++
 tb/tb_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory and the decode stage.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              run;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              busy;

    modport slave (
        input  run, redirect_valid, redirect_pc,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        output busy
    );

    modport master (
        output run, redirect_valid, redirect_pc,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        input  busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch FSM: issues PC-addressed reads, holds each
// fetched word for downstream, and drops in-flight responses after a redirect.
module fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int STEP     = 4,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [2:0]        w_restart;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] r_instr_data;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              w_capture;

    always_comb begin
        w_restart = bus.run ? S_REQ : S_IDLE;
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: w_next = w_restart;
            S_REQ: begin
                // An accepted request still owes a response, so a redirect must drain it.
                if (bus.redirect_valid)     w_next = bus.mem_req_ready ? S_DRAIN : w_restart;
                else if (bus.mem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.redirect_valid) w_next = bus.mem_rsp_valid ? w_restart : S_DRAIN;
                else if (bus.mem_rsp_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD:  if (bus.redirect_valid || bus.instr_ready) w_next = w_restart;
            S_DRAIN: if (bus.mem_rsp_valid) w_next = w_restart;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        if (bus.redirect_valid) w_pc_next = bus.redirect_pc;
        else if (w_capture)     w_pc_next = r_pc + ADDR_W'(STEP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= ADDR_W'(RESET_PC);
            r_instr_data <= '0;
            r_instr_pc   <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_capture) begin
                r_instr_data <= bus.mem_rsp_data;
                r_instr_pc   <= r_pc;
            end
        end
    end

    assign bus.mem_req_valid = (r_state == S_REQ);
    assign bus.mem_req_addr  = r_pc;
    assign bus.instr_valid   = (r_state == S_HOLD);
    assign bus.instr_data    = r_instr_data;
    assign bus.instr_pc      = r_instr_pc;
    assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench with a latency-programmable memory model and an in-order scoreboard
// of expected fetch addresses popped on each downstream handshake.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rsp_lat = 0;

    logic [7:0] exp_q[$];
    int         pop_cyc[$];

    fetch_sequencer_if #(.ADDR_W(8), .DATA_W(32)) b();
    fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .STEP(4), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [7:0] a);
        return {8'hC3, ~a, a, a ^ 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!b.instr_valid && n < max) begin step(1); n++; end
        if (!b.instr_valid) chk("tmo_instr_valid", 0, 1);
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!b.mem_req_valid && n < max) begin step(1); n++; end
        if (!b.mem_req_valid) chk("tmo_mem_req", 0, 1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_req_v", 32'(b.mem_req_valid), 0);
        chk("rst_iv", 32'(b.instr_valid), 0);
        chk("rst_busy", 32'(b.busy), 0);
        chk("rst_idata", b.instr_data, 0);
        chk("rst_ipc", 32'(b.instr_pc), 0);
    endtask

    // Memory model: sees accepts at negedge, drives responses #1 after the edge.
    logic       m_acc;
    logic [7:0] m_acc_addr;
    logic       m_rst;
    logic       m_pend = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_addr;

    always @(negedge clk) begin
        m_acc      = rst_n && b.mem_req_valid && b.mem_req_ready;
        m_acc_addr = b.mem_req_addr;
        m_rst      = !rst_n;
    end

    always @(posedge clk) begin
        #1;
        b.mem_rsp_valid = 1'b0;
        b.mem_rsp_data  = '0;
        if (m_rst) m_pend = 1'b0;
        else begin
            if (m_acc) begin
                m_pend = 1'b1;
                m_cnt  = rsp_lat;
                m_addr = m_acc_addr;
            end
            if (m_pend) begin
                if (m_cnt == 0) begin
                    b.mem_rsp_valid = 1'b1;
                    b.mem_rsp_data  = mdata(m_addr);
                    m_pend          = 1'b0;
                end else m_cnt--;
            end
        end
    end

    // Scoreboard: a handshake that is not overridden by redirect/reset retires one entry.
    always @(negedge clk) begin
        if (rst_n && b.instr_valid && b.instr_ready && !b.redirect_valid) begin
            if (exp_q.size() == 0) chk("unexpected_instr", 32'(b.instr_pc), 32'hFFFF_FFFF);
            else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("instr_pc", 32'(b.instr_pc), 32'(e));
                chk("instr_data", b.instr_data, mdata(e));
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        b.run = 1'b0; b.redirect_valid = 1'b0; b.redirect_pc = '0;
        b.mem_req_ready = 1'b1; b.instr_ready = 1'b1;
        b.mem_rsp_valid = 1'b0; b.mem_rsp_data = '0;
        step(3);
        chk_reset_outs();

        // Sequential fetch, one idle cycle of memory latency.
        rsp_lat = 1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
        rst_n = 1'b1; b.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(20);
            if (i == 2) b.run = 1'b0;
            step(1);
        end
        step(2);
        chk("seq_idle", 32'(b.busy), 0);
        chk("seq_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("seq_period0", pop_cyc[1] - pop_cyc[0], 4);
            chk("seq_period1", pop_cyc[2] - pop_cyc[1], 4);
        end

        // Backpressure in HOLD.
        rsp_lat = 0;
        exp_q.push_back(8'h0C);
        b.instr_ready = 1'b0; b.run = 1'b1;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_iv", 32'(b.instr_valid), 1);
            chk("hold_ipc", 32'(b.instr_pc), 32'h0C);
            chk("hold_idata", b.instr_data, mdata(8'h0C));
            chk("hold_noreq", 32'(b.mem_req_valid), 0);
            step(1);
        end
        b.instr_ready = 1'b1; b.run = 1'b0;
        step(1);

        // Redirect while waiting; stale response arrives later and must be dropped.
        rsp_lat = 3; b.run = 1'b1;
        wait_req(10);
        chk("wr_addr", 32'(b.mem_req_addr), 32'h10);
        step(1);
        b.redirect_valid = 1'b1; b.redirect_pc = 8'h40;
        step(1);
        b.redirect_valid = 1'b0;
        chk("drain_noreq", 32'(b.mem_req_valid), 0);
        chk("drain_busy", 32'(b.busy), 1);
        chk("drain_iv", 32'(b.instr_valid), 0);
        exp_q.push_back(8'h40);
        wait_req(10);
        chk("redir_addr", 32'(b.mem_req_addr), 32'h40);
        rsp_lat = 0;
        wait_valid(20);
        b.run = 1'b0;
        step(1);

        // PC wrap at the top of the address space.
        b.redirect_valid = 1'b1; b.redirect_pc = 8'hFC;
        step(1);
        b.redirect_valid = 1'b0;
        chk("idle_redir_busy", 32'(b.busy), 0);
        exp_q.push_back(8'hFC);
        b.run = 1'b1;
        wait_valid(20);
        step(1);
        chk("wrap_req_v", 32'(b.mem_req_valid), 1);
        chk("wrap_addr", 32'(b.mem_req_addr), 32'h00);
        exp_q.push_back(8'h00);
        wait_valid(20);
        b.run = 1'b0;
        step(1);

        // Redirect withdraws an unaccepted request without draining.
        b.mem_req_ready = 1'b0; b.run = 1'b1;
        wait_req(10);
        for (int i = 0; i < 4; i++) begin
            chk("stall_addr", 32'(b.mem_req_addr), 32'h04);
            step(1);
        end
        b.redirect_valid = 1'b1; b.redirect_pc = 8'h10;
        step(1);
        b.redirect_valid = 1'b0;
        chk("wd_req_v", 32'(b.mem_req_valid), 1);
        chk("wd_addr", 32'(b.mem_req_addr), 32'h10);
        b.mem_req_ready = 1'b1;
        exp_q.push_back(8'h10);
        wait_valid(20);
        b.run = 1'b0;
        step(1);

        // Reset while a request is outstanding.
        rsp_lat = 3; b.run = 1'b1;
        wait_req(10);
        step(1);
        rst_n = 1'b0;
        step(1);
        chk_reset_outs();
        step(1);
        rsp_lat = 0;
        exp_q.push_back(8'h00);
        rst_n = 1'b1;
        wait_req(10);
        chk("post_rst_addr", 32'(b.mem_req_addr), 32'h00);
        wait_valid(20);
        b.run = 1'b0;
        step(1);

        // Redirect in HOLD discards the held word even with instr_ready high.
        b.instr_ready = 1'b0; b.run = 1'b1;
        wait_valid(20);
        chk("hold2_ipc", 32'(b.instr_pc), 32'h04);
        b.instr_ready = 1'b1; b.redirect_valid = 1'b1; b.redirect_pc = 8'h80;
        step(1);
        b.redirect_valid = 1'b0;
        chk("hredir_iv", 32'(b.instr_valid), 0);
        chk("hredir_req_v", 32'(b.mem_req_valid), 1);
        chk("hredir_addr", 32'(b.mem_req_addr), 32'h80);
        exp_q.push_back(8'h80);
        wait_valid(20);
        b.run = 1'b0;
        step(3);
        chk("end_q_empty", exp_q.size(), 0);
        chk("end_idle", 32'(b.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
